led_status_sequencer: RTL and testbench
=======================================

Name: led_status_sequencer

Overview:
- Drives the three PWM inputs of the on-chip RGB LED current driver (RGB0PWM/RGB1PWM/RGB2PWM) from 150 MHz sys_clk.
- Replaces the free-running blink counter with a commanded pattern engine: off, solid, blink, breathe, and N-pulse status codes.
- Upstream logic writes commands through a valid/ready handshake; rgb_pwm connects directly to the LED driver.

Parameters:
- TICK_DIV, 150000, sys_clk cycles per time-base tick (1 ms at 150 MHz); must be >= 2.
- BLINK_TICKS, 250, ticks per ON phase and per OFF phase in BLINK and CODE modes; must be >= 1.
- PAUSE_TICKS, 1000, ticks of dark pause after each CODE burst; must be >= 1.

Ports:
- sys_clk  in  1  system clock, PLL output, 150 MHz.
- sys_rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_mode  in  3  0 OFF, 1 SOLID, 2 BLINK, 3 BREATHE, 4 CODE, 5-7 reserved.
- cmd_color  in  3  channel enable mask; bit i gates rgb_pwm[i].
- cmd_arg  in  4  pulse count N for CODE mode.
- rgb_pwm  out  3  registered PWM to the LED driver, bit0 = RGB0.
- active_mode  out  3  mode currently executing.

Behaviour:
- Reset: sys_rst_n low asynchronously clears all state, at any time including mid-pattern.
  - rgb_pwm = 3'b000, active_mode = 0 (OFF), cmd_ready = 1.
  - Tick prescaler, PWM counter, phase counter, pulse counter and duty = 0; CODE FSM = C_ON.
- Time base: prescaler counts 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1. It free-runs and is never cleared by commands, so the first phase after a command may be up to one tick short.
- PWM:
  - 8-bit pwm_cnt free-runs 0..255 and wraps.
  - Raw output is pwm_cnt < duty, except duty = 255 gives constant high. duty = 0 gives constant low.
  - Next-state rgb_pwm[i] = raw & color[i].
- Handshake:
  - Accept on the rising edge where cmd_valid & cmd_ready.
  - That edge loads mode/color/arg and active_mode, clears the phase counter, and restarts the pattern: BLINK starts ON, BREATHE starts at duty 0 rising, CODE starts in C_ON with pulse 1.
  - rgb_pwm reflects the new command from the next edge onward (1-cycle latency).
  - cmd_valid without cmd_ready: no effect; the command must be held until accepted.
  - Reserved modes 5-7 are accepted and executed as OFF; active_mode reports the raw code.
- cmd_ready: 1 in all modes except CODE in states C_ON/C_OFF, where it is 0. A CODE burst is never truncated; new commands are accepted only during C_PAUSE.
- Modes (all counting on tick only):
  - OFF: duty = 0.
  - SOLID: duty = 255.
  - BLINK: duty alternates 255/0, each phase BLINK_TICKS ticks.
  - BREATHE: duty +1 per tick to 255, then -1 per tick to 0, then repeat. Period is 510 ticks; no dwell at the endpoints.
  - CODE: FSM with N = cmd_arg, and N = 0 treated as 1.
    - C_ON (duty 255) lasts BLINK_TICKS, then goes to C_OFF.
    - C_OFF (duty 0) lasts BLINK_TICKS. If pulse == N, go to C_PAUSE; else pulse + 1 and go to C_ON.
    - C_PAUSE (duty 0) lasts PAUSE_TICKS, then pulse = 1 and go to C_ON.
- Width rules: the phase counter is sized for max(BLINK_TICKS, PAUSE_TICKS); the pulse counter is 4 bits. No overflow is possible.

Test Plan:
- Use TICK_DIV=4, BLINK_TICKS=3, PAUSE_TICKS=8.
- Reset: hold sys_rst_n low for 5 cycles, release -> rgb_pwm=000, cmd_ready=1, active_mode=0. Assert reset mid-BREATHE -> rgb_pwm=000 in the same cycle, with no clock edge needed.
- SOLID, color=3'b101 -> rgb_pwm=101 on every cycle from the edge after accept; bit1 stays 0.
- BLINK, color=3'b001 -> rgb_pwm[0] high for 12 cycles then low for 12, repeating (first ON phase 9-12 cycles).
- CODE, arg=3, color=3'b010 -> three 12-cycle pulses separated by 12-cycle gaps, then 32 cycles dark, then repeat.
  - cmd_ready = 0 during the pulses and 1 in the pause.
  - A SOLID command held valid mid-burst is accepted on the first C_PAUSE cycle.
- CODE, arg=0 -> single pulse per burst. cmd_mode=6 -> rgb_pwm=000 and active_mode=6.
- BREATHE, color=3'b111 -> after 128 ticks, duty=128 (rgb_pwm high 128 of 256 cycles). Duty peaks at 255 (constant high) after 255 ticks and returns to 0 at tick 510.

Source files
------------

// File: rtl/led_status_sequencer.sv
// Commanded RGB LED pattern engine: off, solid, blink, breathe and N-pulse status codes.
// A free-running 1 ms time base paces the patterns, and an 8-bit PWM sets the brightness.

module led_pwm_lane (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic raw,
  input  logic en,
  output logic pwm
);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) pwm <= 1'b0;
    else            pwm <= raw & en;
endmodule

module led_status_sequencer #(
  parameter int TICK_DIV    = 150000,
  parameter int BLINK_TICKS = 250,
  parameter int PAUSE_TICKS = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_mode,
  input  logic [2:0] cmd_color,
  input  logic [3:0] cmd_arg,
  output logic [2:0] rgb_pwm,
  output logic [2:0] active_mode
);
  localparam int NUM_LANES = 3;
  localparam int PRE_W     = $clog2(TICK_DIV);
  localparam int PH_MAX    = (BLINK_TICKS > PAUSE_TICKS) ? BLINK_TICKS : PAUSE_TICKS;
  localparam int PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [2:0] MODE_SOLID   = 3'd1;
  localparam logic [2:0] MODE_BLINK   = 3'd2;
  localparam logic [2:0] MODE_BREATHE = 3'd3;
  localparam logic [2:0] MODE_CODE    = 3'd4;

  typedef struct packed {
    logic [2:0] mode;
    logic [2:0] color;
    logic [3:0] arg;
  } cmd_t;

  typedef enum logic [1:0] {C_ON, C_OFF, C_PAUSE} code_e;

  cmd_t            cur;
  code_e           cst, cst_nxt;
  logic [PRE_W-1:0] pre;
  logic [7:0]      pwm_cnt;
  logic [PH_W-1:0] ph_cnt, ph_lim;
  logic [3:0]      pulse, n_eff;
  logic [7:0]      br_lvl, duty;
  logic            br_up, blink_on;
  logic            tick, accept, ph_end, code_step, last_pulse, raw;

  assign tick        = (pre == PRE_W'(TICK_DIV - 1));
  assign accept      = cmd_valid & cmd_ready;
  assign cmd_ready   = !((cur.mode == MODE_CODE) && (cst != C_PAUSE));
  assign active_mode = cur.mode;
  assign n_eff       = (cur.arg == 4'd0) ? 4'd1 : cur.arg;
  assign last_pulse  = (pulse >= n_eff);
  assign ph_lim      = ((cur.mode == MODE_CODE) && (cst == C_PAUSE)) ?
                       PH_W'(PAUSE_TICKS - 1) : PH_W'(BLINK_TICKS - 1);
  assign ph_end      = (ph_cnt == ph_lim);
  assign code_step   = tick & ph_end & (cur.mode == MODE_CODE);

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cst <= C_ON;
    else            cst <= cst_nxt;

  always_comb begin
    cst_nxt = cst;
    if (accept) cst_nxt = C_ON;
    else if (code_step) begin
      case (cst)
        C_ON:    cst_nxt = C_OFF;
        C_OFF:   cst_nxt = last_pulse ? C_PAUSE : C_ON;
        default: cst_nxt = C_ON;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre      <= '0;
      pwm_cnt  <= '0;
      ph_cnt   <= '0;
      cur      <= '0;
      blink_on <= 1'b0;
      br_lvl   <= '0;
      br_up    <= 1'b1;
      pulse    <= '0;
    end else begin
      // The time base is never resynchronised to commands.
      pre     <= tick ? '0 : pre + 1'b1;
      pwm_cnt <= pwm_cnt + 8'd1;
      if (accept) begin
        cur      <= {cmd_mode, cmd_color, cmd_arg};
        ph_cnt   <= '0;
        blink_on <= 1'b1;
        br_lvl   <= '0;
        br_up    <= 1'b1;
        pulse    <= 4'd1;
      end else if (tick) begin
        ph_cnt <= ph_end ? '0 : ph_cnt + 1'b1;
        if (ph_end) blink_on <= ~blink_on;
        if (cur.mode == MODE_BREATHE) begin
          if (br_up) begin
            br_lvl <= br_lvl + 8'd1;
            if (br_lvl == 8'd254) br_up <= 1'b0;
          end else begin
            br_lvl <= br_lvl - 8'd1;
            if (br_lvl == 8'd1) br_up <= 1'b1;
          end
        end
        if (code_step) begin
          if (cst == C_OFF && !last_pulse) pulse <= pulse + 4'd1;
          else if (cst == C_PAUSE)         pulse <= 4'd1;
        end
      end
    end
  end

  // Reserved modes fall through to dark.
  always_comb begin
    duty = 8'd0;
    case (cur.mode)
      MODE_SOLID:   duty = 8'hFF;
      MODE_BLINK:   duty = blink_on ? 8'hFF : 8'h00;
      MODE_BREATHE: duty = br_lvl;
      MODE_CODE:    duty = (cst == C_ON) ? 8'hFF : 8'h00;
      default:      duty = 8'd0;
    endcase
  end

  assign raw = (duty == 8'hFF) | (pwm_cnt < duty);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    led_pwm_lane u_lane (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .raw      (raw),
      .en       (cur.color[i]),
      .pwm      (rgb_pwm[i])
    );
  end
endmodule

// File: tb/tb_led_status_sequencer.sv
// Bench for led_status_sequencer: a run-length monitor pops expected rgb_pwm segments
// from a scoreboard queue that the stimulus fills as it issues commands.

module tb_led_status_sequencer;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_mode = '0, cmd_color = '0;
  logic [3:0] cmd_arg = '0;
  logic       cmd_ready;
  logic [2:0] rgb_pwm, active_mode;

  led_status_sequencer #(.TICK_DIV(4), .BLINK_TICKS(3), .PAUSE_TICKS(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_color  (cmd_color),
    .cmd_arg    (cmd_arg),
    .rgb_pwm    (rgb_pwm),
    .active_mode(active_mode)
  );

  always #5 sys_clk = ~sys_clk;

  // Cycles since reset release; state advances on tick at edges where cyc % 4 == 0.
  int cyc;
  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  typedef struct { logic [2:0] val; int lo; int hi; } seg_t;
  seg_t       exp_q[$];
  int         skip = 0, seg_n = 0, run_len = 0;
  bit         mon_on = 1'b0;
  logic [2:0] mcur = '0;

  always @(negedge sys_clk) begin
    seg_t e;
    if (!sys_rst_n) begin
      mcur    = rgb_pwm;
      run_len = 0;
    end else if (rgb_pwm !== mcur) begin
      if (skip > 0) skip--;
      else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        seg_n++;
        chk($sformatf("seg%0d_val", seg_n), int'(mcur), int'(e.val));
        chk_rng($sformatf("seg%0d_len", seg_n), run_len, e.lo, e.hi);
      end else if (mon_on) begin
        checks++;
        errors++;
        $display("FAIL unexpected_seg: value %b held %0d cycles, none expected", mcur, run_len);
      end
      mcur    = rgb_pwm;
      run_len = 1;
    end else run_len++;
  end

  task automatic push(input logic [2:0] v, input int lo, input int hi);
    exp_q.push_back('{val: v, lo: lo, hi: hi});
  endtask

  task automatic arm();
    exp_q.delete();
    skip   = 1;
    mon_on = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    mon_on    = 1'b0;
    skip      = 0;
    exp_q.delete();
    cmd_valid = 1'b0;
    sys_rst_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic send_cmd(input logic [2:0] m, input logic [2:0] c, input logic [3:0] a,
                          output int acc, output int waited);
    logic r;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b1; cmd_mode = m; cmd_color = c; cmd_arg = a;
    waited = 0;
    r = 1'b0;
    while (!r && waited <= 500) begin
      @(negedge sys_clk);
      r = cmd_ready;
      @(posedge sys_clk);
      if (!r) waited++;
    end
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: mode %0d not accepted after %0d cycles", m, waited);
    end
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_qsize(input string name, input int n);
    int b = 0;
    while (exp_q.size() > n && b < 3000) begin
      @(posedge sys_clk); #1;
      b++;
    end
    chk({name, "_pending"}, exp_q.size(), n);
  endtask

  task automatic wait_ticks(input int n);
    int t = 0;
    while (t < n) begin
      @(posedge sys_clk); #1;
      if (cyc % 4 == 0) t++;
    end
  endtask

  task automatic count_hi4(output int hi);
    hi = 0;
    @(posedge sys_clk);
    repeat (4) begin
      @(negedge sys_clk);
      if (rgb_pwm == 3'b111) hi++;
    end
  endtask

  initial begin
    int a, a2, b, w, hi, bud;

    #1 sys_rst_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    chk("rst_rgb_held", int'(rgb_pwm), 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_rgb", int'(rgb_pwm), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_mode", int'(active_mode), 0);

    // SOLID on channels 0 and 2, closed by an OFF command.
    do_reset(); arm();
    send_cmd(3'd1, 3'b101, 4'd0, a, w);
    chk("solid_mode", int'(active_mode), 1);
    repeat (40) @(posedge sys_clk);
    send_cmd(3'd0, 3'b000, 4'd0, b, w);
    push(3'b101, b - a, b - a);
    wait_qsize("solid", 0);

    do_reset(); arm();
    send_cmd(3'd2, 3'b001, 4'd0, a, w);
    chk("blink_mode", int'(active_mode), 2);
    push(3'b001, 9, 12);
    for (int i = 0; i < 2; i++) begin
      push(3'b000, 12, 12);
      push(3'b001, 12, 12);
    end
    wait_qsize("blink", 0);

    // CODE N=3: three pulses, merged last gap + pause, then the next burst begins.
    do_reset(); arm();
    send_cmd(3'd4, 3'b010, 4'd3, a, w);
    chk("code_ready_burst", int'(cmd_ready), 0);
    chk("code_mode", int'(active_mode), 4);
    push(3'b010, 9, 12);
    push(3'b000, 12, 12); push(3'b010, 12, 12);
    push(3'b000, 12, 12); push(3'b010, 12, 12);
    push(3'b000, 44, 44);
    push(3'b010, 12, 12); push(3'b000, 12, 12);
    wait_qsize("code_p3", 3);
    chk("code_ready_off", int'(cmd_ready), 0);
    repeat (20) @(posedge sys_clk);
    #1;
    chk("code_ready_pause", int'(cmd_ready), 1);
    wait_qsize("code", 0);

    // SOLID held valid mid-burst must land on the first pause cycle.
    do_reset(); arm();
    send_cmd(3'd4, 3'b010, 4'd3, a, w);
    push(3'b010, 9, 12);
    push(3'b000, 12, 12); push(3'b010, 12, 12);
    push(3'b000, 12, 12); push(3'b010, 12, 12);
    push(3'b000, 13, 13);
    send_cmd(3'd1, 3'b010, 4'd0, a2, w);
    chk_rng("hold_wait", w, 68, 71);
    chk("hold_mode", int'(active_mode), 1);
    repeat (20) @(posedge sys_clk);
    send_cmd(3'd0, 3'b000, 4'd0, b, w);
    push(3'b010, b - a2, b - a2);
    wait_qsize("hold", 0);

    do_reset(); arm();
    send_cmd(3'd4, 3'b111, 4'd0, a, w);
    push(3'b111, 9, 12); push(3'b000, 44, 44);
    push(3'b111, 12, 12); push(3'b000, 44, 44);
    wait_qsize("code0", 0);

    do_reset(); arm();
    send_cmd(3'd1, 3'b111, 4'd0, a, w);
    repeat (10) @(posedge sys_clk);
    send_cmd(3'd6, 3'b111, 4'd0, b, w);
    push(3'b111, b - a, b - a);
    repeat (30) @(posedge sys_clk);
    #1;
    chk("rsvd_rgb", int'(rgb_pwm), 0);
    chk("rsvd_mode", int'(active_mode), 6);
    chk("rsvd_ready", int'(cmd_ready), 1);
    wait_qsize("rsvd", 0);

    do_reset();
    send_cmd(3'd3, 3'b111, 4'd0, a, w);
    chk("br_mode", int'(active_mode), 3);
    wait_ticks(128);
    chk("br_duty128", int'(dut.duty), 128);
    wait_ticks(127);
    chk("br_duty255", int'(dut.duty), 255);
    count_hi4(hi);
    chk("br_peak_hi", hi, 4);
    chk("br_no_dwell", int'(dut.duty), 254);
    wait_ticks(254);
    chk("br_duty510", int'(dut.duty), 0);
    count_hi4(hi);
    chk("br_floor_hi", hi, 0);
    chk("br_rise_again", int'(dut.duty), 1);

    // Asynchronous reset while the LED is lit mid-breathe.
    bud = 0;
    do begin
      @(negedge sys_clk);
      bud++;
    end while (rgb_pwm != 3'b111 && bud < 2000);
    chk("br_lit_before_rst", int'(rgb_pwm), 7);
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", int'(rgb_pwm), 0);
    chk("async_rst_mode", int'(active_mode), 0);
    chk("async_rst_ready", int'(cmd_ready), 1);
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
